// File: rtl/time_set_ctrl.sv
// ----------------------------------------------------------------------------
// time_set_ctrl
//
// Manual time / alarm setting sequencer for the digital clock.
// In clock (00) or alarm (01) mode, key_set enters edit mode and walks
// hour -> minute -> second -> commit. key_inc / key_dec adjust the selected
// field with wrap-around. Commit emits a one-cycle load pulse toward the
// time counter (target 00) or the alarm register (target 01). A mode change
// while editing abandons the edit without loading anything.
//
// Optional build macro:
//   TIME_SET_AUTO_EXIT_EN - when defined, an edit abandoned for
//   CLK_FREQ*TIMEOUT_S cycles without any key pulse is aborted to IDLE.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   model[1:0]                  current mode (00 clk, 01 alarm, 10/11 other)
//   key_set, key_inc, key_dec   debounced single-cycle key pulses
//   cur_hour/min/sec            present value of the selected source
//   set_hour/min/sec            edited value (registered)
//   load_time, load_alarm       one-cycle commit pulses (registered)
//   editing                     high in the hour/minute/second edit states
//   field_sel[1:0]              00 none, 01 hour, 10 minute, 11 second
//   blink                       display enable for the edited field (1=show)
// ----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] model,
    input  logic       key_set,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load_time,
    output logic       load_alarm,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int BLINK_HALF_RAW = CLK_FREQ / (2 * BLINK_HZ);
    localparam int BLINK_HALF     = (BLINK_HALF_RAW < 1) ? 1 : BLINK_HALF_RAW;
    localparam int BLINK_W        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_S  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [1:0]         target_r;
    logic [1:0]         target_nx_s;
    logic [4:0]         hour_nx_s;
    logic [5:0]         min_nx_s;
    logic [5:0]         sec_nx_s;
    logic [1:0]         field_nx_s;
    logic               in_edit_s;
    logic               next_edit_s;
    logic               inc_only_s;
    logic               dec_only_s;
    logic               adjust_s;
    logic               restart_s;
    logic               timeout_s;
    logic [BLINK_W-1:0] blink_cnt_r;

    // Hour field step with wrap 23 <-> 0.
    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        logic [4:0] r;
        if (up) begin
            if (h >= 5'd23) r = 5'd0;
            else            r = h + 5'd1;
        end else begin
            if (h == 5'd0)  r = 5'd23;
            else            r = h - 5'd1;
        end
        return r;
    endfunction

    // Minute / second field step with wrap 59 <-> 0.
    function automatic logic [5:0] sexa_step(input logic [5:0] v, input logic up);
        logic [5:0] r;
        if (up) begin
            if (v >= 6'd59) r = 6'd0;
            else            r = v + 6'd1;
        end else begin
            if (v == 6'd0)  r = 6'd59;
            else            r = v - 6'd1;
        end
        return r;
    endfunction

    assign in_edit_s  = (state_r == SET_H) || (state_r == SET_M) || (state_r == SET_S);
    // Pressing inc and dec together cancels both.
    assign inc_only_s = key_inc & ~key_dec;
    assign dec_only_s = key_dec & ~key_inc;

`ifdef TIME_SET_AUTO_EXIT_EN
    localparam int TMO_RAW = CLK_FREQ * TIMEOUT_S;
    localparam int TMO_CYC = (TMO_RAW < 1) ? 1 : TMO_RAW;
    localparam int TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             key_any_s;

    assign key_any_s = key_set | key_inc | key_dec;
    // Fires on the cycle that would complete the full idle interval.
    assign timeout_s = in_edit_s && !key_any_s && (tmo_cnt_r == TMO_LAST);

    // Inactivity counter: cleared outside edit mode and by any key pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (!in_edit_s || key_any_s) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, edited-value and target selection.
    always_comb begin
        state_nx_s  = state_r;
        target_nx_s = target_r;
        hour_nx_s   = set_hour;
        min_nx_s    = set_min;
        sec_nx_s    = set_sec;
        adjust_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (key_set && (model[1] == 1'b0)) begin
                    state_nx_s  = SET_H;
                    target_nx_s = model;
                    hour_nx_s   = cur_hour;
                    min_nx_s    = cur_min;
                    sec_nx_s    = cur_sec;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            SET_H, SET_M, SET_S: begin
                if ((model != target_r) || timeout_s) begin
                    // Abort keeps set_* as they are and emits no load.
                    state_nx_s = IDLE;
                end else if (key_set) begin
                    case (state_r)
                        SET_H:   state_nx_s = SET_M;
                        SET_M:   state_nx_s = SET_S;
                        SET_S:   state_nx_s = COMMIT;
                        default: state_nx_s = IDLE;
                    endcase
                end else if (inc_only_s || dec_only_s) begin
                    adjust_s = 1'b1;
                    case (state_r)
                        SET_H:   hour_nx_s = hour_step(set_hour, inc_only_s);
                        SET_M:   min_nx_s  = sexa_step(set_min, inc_only_s);
                        SET_S:   sec_nx_s  = sexa_step(set_sec, inc_only_s);
                        default: hour_nx_s = set_hour;
                    endcase
                end else begin
                    state_nx_s = state_r;
                end
            end
            COMMIT:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Decode of the upcoming state into registered display/edit outputs.
    always_comb begin
        field_nx_s  = 2'b00;
        next_edit_s = 1'b0;
        case (state_nx_s)
            SET_H: begin
                field_nx_s  = 2'b01;
                next_edit_s = 1'b1;
            end
            SET_M: begin
                field_nx_s  = 2'b10;
                next_edit_s = 1'b1;
            end
            SET_S: begin
                field_nx_s  = 2'b11;
                next_edit_s = 1'b1;
            end
            default: begin
                field_nx_s  = 2'b00;
                next_edit_s = 1'b0;
            end
        endcase
        // Entering a field or adjusting it restarts the blink phase so the
        // new value is shown at once.
        restart_s = next_edit_s && ((state_nx_s != state_r) || adjust_s);
    end

    // FSM state, commit target and edited field values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            target_r <= 2'b00;
            set_hour <= 5'd0;
            set_min  <= 6'd0;
            set_sec  <= 6'd0;
        end else begin
            state_r  <= state_nx_s;
            target_r <= target_nx_s;
            set_hour <= hour_nx_s;
            set_min  <= min_nx_s;
            set_sec  <= sec_nx_s;
        end
    end

    // Registered status and load pulses; COMMIT lasts one cycle so the
    // load is a single pulse by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            editing    <= 1'b0;
            field_sel  <= 2'b00;
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
        end else begin
            editing    <= next_edit_s;
            field_sel  <= field_nx_s;
            load_time  <= (state_nx_s == COMMIT) && (target_r == 2'b00);
            load_alarm <= (state_nx_s == COMMIT) && (target_r == 2'b01);
        end
    end

    // Blink phase generator for the field under edit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            blink       <= 1'b1;
        end else if (!next_edit_s || restart_s) begin
            blink_cnt_r <= '0;
            blink       <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink       <= ~blink;
        end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
            blink       <= blink;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Directed scenarios followed by random key/mode traffic, all compared every
// cycle against a behavioural model (edit phase number, field value array
// with modular arithmetic, blink derived from cycles since last restart).
// Build with +define+TIME_SET_AUTO_EXIT_EN to cover the timeout option.
// ----------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int CLK_FREQ  = 8;
    localparam int BLINK_HZ  = 1;
    localparam int TIMEOUT_S = 2;
    localparam int HALF      = CLK_FREQ / (2 * BLINK_HZ);
    localparam int TMO_LIMIT = CLK_FREQ * TIMEOUT_S;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] model;
    logic       key_set, key_inc, key_dec;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       load_time, load_alarm, editing, blink;
    logic [1:0] field_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ph 0 idle, 1..3 editing field ph, 4 commit cycle.
    int ph, tgt, age, tmo;
    int v[3];
    int lim[3] = '{24, 60, 60};

    time_set_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .BLINK_HZ (BLINK_HZ),
        .TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .model     (model),
        .key_set   (key_set),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .load_time (load_time),
        .load_alarm(load_alarm),
        .editing   (editing),
        .field_sel (field_sel),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; tgt = 0; age = 0; tmo = 0;
        v[0] = 0; v[1] = 0; v[2] = 0;
    endtask

    task automatic model_update(input logic s, input logic i, input logic d, input logic [1:0] m);
        logic any;
        any = s | i | d;
        if (ph == 0) begin
            if (s && (m < 2'd2)) begin
                v[0] = int'(cur_hour); v[1] = int'(cur_min); v[2] = int'(cur_sec);
                tgt = int'(m); ph = 1; age = 0; tmo = 0;
            end
        end else if (ph == 4) begin
            ph = 0;
        end else begin
            tmo = any ? 0 : tmo + 1;
            if (int'(m) != tgt) begin
                ph = 0;
`ifdef TIME_SET_AUTO_EXIT_EN
            end else if (tmo == TMO_LIMIT) begin
                ph = 0;
`endif
            end else if (s) begin
                ph = ph + 1;
                age = 0;
            end else if (i && !d) begin
                v[ph-1] = (v[ph-1] + 1) % lim[ph-1];
                age = 0;
            end else if (d && !i) begin
                v[ph-1] = (v[ph-1] + lim[ph-1] - 1) % lim[ph-1];
                age = 0;
            end else begin
                age++;
            end
        end
    endtask

    task automatic check_all(input string p);
        int ed;
        ed = (ph >= 1 && ph <= 3) ? 1 : 0;
        chk({p, ":set_hour"},   32'(set_hour),   32'(v[0]));
        chk({p, ":set_min"},    32'(set_min),    32'(v[1]));
        chk({p, ":set_sec"},    32'(set_sec),    32'(v[2]));
        chk({p, ":editing"},    32'(editing),    32'(ed));
        chk({p, ":field_sel"},  32'(field_sel),  32'(ed ? ph : 0));
        chk({p, ":load_time"},  32'(load_time),  32'((ph == 4 && tgt == 0) ? 1 : 0));
        chk({p, ":load_alarm"}, 32'(load_alarm), 32'((ph == 4 && tgt == 1) ? 1 : 0));
        chk({p, ":blink"},      32'(blink),      32'(ed ? (((age / HALF) % 2 == 0) ? 1 : 0) : 1));
    endtask

    // One clock: hold inputs across the edge, advance the model, check #1 later.
    task automatic step(input logic s, input logic i, input logic d, input logic [1:0] m);
        key_set = s; key_inc = i; key_dec = d; model = m;
        @(posedge clk);
        model_update(s, i, d, m);
        #1;
        key_set = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        check_all("cyc");
    endtask

    task automatic set_cur(input int h, input int mi, input int se);
        cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(se);
    endtask

    initial begin
        int exp_a[5];
        int exp_b[4];
        logic [1:0] m;
        exp_a = '{1, 1, 1, 0, 0};
        exp_b = '{1, 1, 1, 0};

        rst_n = 1'b0; model = 2'b00;
        key_set = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        set_cur(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'b00);

        // Full clock set: 12:34:56 -> 15:33:56
        set_cur(12, 34, 56);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("clk_enter_field", 32'(field_sel), 32'd1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("clk_no_early_load", 32'(load_time), 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("clk_load_time", 32'(load_time), 32'd1);
        chk("clk_load_alarm", 32'(load_alarm), 32'd0);
        chk("clk_value", {15'd0, set_hour, set_min, set_sec}, {15'd0, 5'd15, 6'd33, 6'd56});
        step(1'b0, 1'b0, 1'b0, 2'b00);
        chk("clk_load_drop", 32'(load_time), 32'd0);
        chk("clk_field_none", 32'(field_sel), 32'd0);

        // Alarm wrap: 23:59:00 -> 00:00:59
        set_cur(23, 59, 0);
        step(1'b1, 1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b1, 1'b0, 2'b01);
        chk("wrap_hour", 32'(set_hour), 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b1, 1'b0, 2'b01);
        chk("wrap_min", 32'(set_min), 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b0, 1'b1, 2'b01);
        chk("wrap_sec", 32'(set_sec), 32'd59);
        step(1'b1, 1'b0, 1'b0, 2'b01);
        chk("wrap_load_alarm", 32'(load_alarm), 32'd1);
        chk("wrap_load_time", 32'(load_time), 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'b01);

        // Abort by mode change in SET_M, then key_set in stopwatch mode
        set_cur(1, 2, 3);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b10);
        chk("abort_editing", 32'(editing), 32'd0);
        chk("abort_no_load", 32'({load_time, load_alarm}), 32'd0);
        chk("abort_retain", 32'(set_hour), 32'd1);
        step(1'b1, 1'b0, 1'b0, 2'b10);
        chk("sw_set_ignored", 32'(editing), 32'd0);

        // Simultaneous keys in SET_H
        set_cur(5, 6, 7);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b00);
        chk("incdec_hour", 32'(set_hour), 32'd5);
        step(1'b1, 1'b1, 1'b0, 2'b00);
        chk("setinc_field", 32'(field_sel), 32'd2);
        chk("setinc_hour", 32'(set_hour), 32'd5);

        // Blink cadence and restart on inc
        step(1'b0, 1'b0, 1'b0, 2'b10);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("blink_entry", 32'(blink), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 2'b00);
            chk("blink_run", 32'(blink), 32'(exp_a[k]));
        end
        step(1'b0, 1'b1, 1'b0, 2'b00);
        chk("blink_inc_show", 32'(blink), 32'd1);
        chk("blink_inc_hour", 32'(set_hour), 32'd6);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 2'b00);
            chk("blink_rerun", 32'(blink), 32'(exp_b[k]));
        end

        // Reset while in SET_S
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("pre_reset_field", 32'(field_sel), 32'd3);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_mid_editing", 32'(editing), 32'd0);
        chk("rst_mid_hour", 32'(set_hour), 32'd0);
        chk("rst_mid_field", 32'(field_sel), 32'd0);
        check_all("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'b00);

        // Inactivity in SET_H
        set_cur(9, 10, 11);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        repeat (TMO_LIMIT) step(1'b0, 1'b0, 1'b0, 2'b00);
`ifdef TIME_SET_AUTO_EXIT_EN
        chk("timeout_exit", 32'(editing), 32'd0);
`else
        chk("no_timeout", 32'(editing), 32'd1);
`endif
        chk("timeout_no_load", 32'({load_time, load_alarm}), 32'd0);
        step(1'b0, 1'b0, 1'b0, 2'b10);
        step(1'b0, 1'b0, 1'b0, 2'b00);

        // Random traffic
        m = 2'b00;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(24) == 0) m = 2'($urandom_range(3));
            set_cur(int'($urandom_range(23)), int'($urandom_range(59)), int'($urandom_range(59)));
            step(($urandom_range(5) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences manual time/alarm setting for the digital clock.
- In mode 00 (clock) or 01 (alarm), the set key walks an edit FSM through the hour, minute and second fields; inc/dec keys adjust the selected field with wrap.
- On commit, a one-cycle load pulse goes to the time counter (mode 00) or the alarm register (mode 01).
- Also drives the field-select and blink signals for the 7-segment display mux.

Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz.
- BLINK_HZ, 2, blink rate of the field being edited; blink toggles every CLK_FREQ/(2*BLINK_HZ) cycles.
- TIMEOUT_S, 10, seconds without a key before auto-exit (used only with AUTO_EXIT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- model  in  2  current mode: 00 clock, 01 alarm, 10 stopwatch, 11 countdown.
- key_set  in  1  debounced single-cycle pulse: enter edit / next field.
- key_inc  in  1  debounced single-cycle pulse: increment selected field.
- key_dec  in  1  debounced single-cycle pulse: decrement selected field.
- cur_hour  in  5  present hour of the selected source (0-23).
- cur_min  in  6  present minute (0-59).
- cur_sec  in  6  present second (0-59).
- set_hour  out  5  edited hour value.
- set_min  out  6  edited minute value.
- set_sec  out  6  edited second value.
- load_time  out  1  one-cycle pulse: write set_* into the time counter.
- load_alarm  out  1  one-cycle pulse: write set_* into the alarm register.
- editing  out  1  high while in SET_H, SET_M or SET_S.
- field_sel  out  2  00 none, 01 hour, 10 minute, 11 second.
- blink  out  1  display enable for the selected field; 1 = show.

Behaviour:
- Reset values: state IDLE; set_* 0; load_* 0; editing 0; field_sel 00; blink 1; target register 00.
- States: IDLE, SET_H, SET_M, SET_S, COMMIT. All outputs are registered.
- IDLE:
  - key_set with model==00 or 01: capture cur_hour/min/sec into set_*, latch target=model, go to SET_H on the next edge.
  - key_set with model 10 or 11: ignored.
  - inc/dec: ignored.
- SET_H -> SET_M -> SET_S -> COMMIT, one step per key_set.
- COMMIT lasts exactly one cycle:
  - load_time=1 if target==00, else load_alarm=1;
  - returns to IDLE on the next cycle;
  - set_* hold their values through COMMIT and stay unchanged in IDLE.
- Load latency: the load pulse is asserted in the cycle after the third key_set that follows entry.
- Field arithmetic:
  - key_inc: hour 23->0, minute/second 59->0, otherwise +1.
  - key_dec: 0->23 (hour) or 0->59 (minute/second), otherwise -1.
  - The update is visible the cycle after the key pulse.
- Simultaneous events:
  - key_inc and key_dec together: both ignored.
  - key_set with inc/dec: key_set wins, the field value is unchanged.
- Abort: model != target in any SET_* state -> IDLE next cycle, no load pulse, set_* retained.
- field_sel: 01/10/11 in SET_H/SET_M/SET_S; 00 in IDLE and COMMIT.
- editing: 1 only in the SET_* states.
- Blink:
  - Counter runs only while editing; blink toggles at each terminal count.
  - Counter clears and blink forces to 1 on field entry and on any inc/dec (value is shown immediately).
  - blink=1 whenever not editing.
- Reset mid-edit: immediate return to reset values; no load pulse.

Optional Feature:
- Macro: TIME_SET_AUTO_EXIT_EN.
- Defined:
  - A timeout counter clears on any key pulse or on entry.
  - When it reaches CLK_FREQ*TIMEOUT_S cycles in a SET_* state, the FSM aborts to IDLE with no load.
  - Abort is identical to the mode-change abort.
- Undefined: no timeout counter is built; edit mode persists until committed, aborted by a mode change, or reset.

Test Plan:
- Bench parameters CLK_FREQ=8, BLINK_HZ=1, TIMEOUT_S=2.
- Full clock set: model=00, cur=12:34:56, key_set, 3x key_inc, key_set, key_dec, key_set, key_set -> set_*=15:33:56, load_time single pulse one cycle after the last key_set, load_alarm stays 0, field_sel back to 00.
- Wrap: alarm mode, cur=23:59:00; in SET_H key_inc -> hour 0; in SET_M key_inc -> minute 0; in SET_S key_dec -> second 59; commit -> load_alarm pulse with 00:00:59.
- Abort: in SET_M change model 00->10 -> IDLE next cycle, no load pulse; later key_set with model=10 -> stays IDLE.
- Simultaneity: in SET_H, inc+dec in the same cycle -> hour unchanged; key_set+inc in the same cycle -> advance to SET_M, hour unchanged.
- Blink: in SET_H with no key, blink toggles every 4 cycles (1,0,1,...); key_inc forces blink=1 and restarts the count.
- Reset and timeout: rst_n low in SET_S -> all outputs at reset values at once. With TIME_SET_AUTO_EXIT_EN, 16 idle cycles in SET_H -> IDLE, no load pulse.
